// File: rtl/mcu_pkg.sv
// Shared MCU fetch-path types: instruction address type and the
// return-address-stack operation decode used by return_addr_stack.
package mcu_pkg;

  localparam int ADDR_W = 10;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } ras_op_t;

  // A combined push+pop on an empty stack has nothing to replace, so it is a plain push.
  function automatic ras_op_t ras_decode(input logic push, input logic pop,
                                         input logic empty, input logic full);
    ras_op_t op;
    op = OP_IDLE;
    if (push && pop)
      op = empty ? OP_PUSH : OP_REPLACE;
    else if (push)
      op = full ? OP_OVERFLOW : OP_PUSH;
    else if (pop)
      op = empty ? OP_UNDERFLOW : OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x ADDR_W array with one synchronous write
// port and one asynchronous read port (maps onto distributed RAM).
module ras_mem #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 32
) (
  input  logic                     CLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [ADDR_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]        rd_data
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware return-address stack beside the PC; RET_ADDR is valid in the POP cycle.
// Define RAS_WRAP_EN to make the stack circular (overflow drops the oldest entry).
module return_addr_stack #(
  parameter int ADDR_W = mcu_pkg::ADDR_W,
  parameter int DEPTH  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic                     POP,
  input  logic [ADDR_W-1:0]        PC_IN,
  output logic [ADDR_W-1:0]        RET_ADDR,
  output logic [$clog2(DEPTH):0]   SP,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ERR
);

  import mcu_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wp;
  logic [PW-1:0]     top_idx;
  logic [PW:0]       sp_q;
  logic              err_q;
  ras_op_t           op;
  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] rd_data;

  assign top_idx = wp - 1'b1;
  assign EMPTY   = (sp_q == '0);
  assign FULL    = (sp_q == (PW+1)'(DEPTH));
  assign SP      = sp_q;
  assign ERR     = err_q;
  assign op      = ras_decode(PUSH, POP, EMPTY, FULL);

  // Replace overwrites the current top; every other write lands at wp. Reset discards the write.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = wp;
    if (!RST) begin
      case (op)
        OP_PUSH:    wr_en = 1'b1;
        OP_REPLACE: begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
`ifdef RAS_WRAP_EN
        OP_OVERFLOW: wr_en = 1'b1;
`endif
        default:    wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp    <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          wp   <= wp + 1'b1;
          sp_q <= sp_q + 1'b1;
        end
        OP_POP: begin
          wp   <= wp - 1'b1;
          sp_q <= sp_q - 1'b1;
        end
`ifdef RAS_WRAP_EN
        OP_OVERFLOW:  wp    <= wp + 1'b1;
`else
        OP_OVERFLOW:  err_q <= 1'b1;
`endif
        OP_UNDERFLOW: err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (PC_IN),
    .rd_idx  (top_idx),
    .rd_data (rd_data)
  );

  assign RET_ADDR = EMPTY ? '0 : rd_data;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack (DEPTH=4) with a queue-based
// reference stack feeding an expected-value scoreboard.
module tb_return_addr_stack;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] sp;
    logic       empty;
    logic       full;
    logic       err;
    logic [9:0] ret;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  v;
  } sb_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PUSH = 1'b0;
  logic       POP = 1'b0;
  logic [9:0] PC_IN = '0;
  logic [9:0] RET_ADDR;
  logic [2:0] SP;
  logic       EMPTY;
  logic       FULL;
  logic       ERR;

  int total = 0;
  int bad = 0;

  logic [9:0] model_stk[$];
  logic       model_err = 1'b0;
  sb_t        exp_q[$];
  sb_t        obs_q[$];

  return_addr_stack #(
    .ADDR_W (10),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH     (PUSH),
    .POP      (POP),
    .PC_IN    (PC_IN),
    .RET_ADDR (RET_ADDR),
    .SP       (SP),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // Reference stack: a plain queue, newest entry at the back.
  task automatic model_step(input logic rst, input logic push, input logic pop,
                            input logic [9:0] pc);
    if (rst) begin
      model_stk.delete();
      model_err = 1'b0;
    end else if (push && pop) begin
      if (model_stk.size() == 0) model_stk.push_back(pc);
      else model_stk[model_stk.size()-1] = pc;
    end else if (push) begin
      if (model_stk.size() < DEPTH) model_stk.push_back(pc);
      else begin
`ifdef RAS_WRAP_EN
        void'(model_stk.pop_front());
        model_stk.push_back(pc);
`else
        model_err = 1'b1;
`endif
      end
    end else if (pop) begin
      if (model_stk.size() > 0) void'(model_stk.pop_back());
      else model_err = 1'b1;
    end
  endtask

  // One clock of stimulus; expected state after the edge goes to the scoreboard.
  task automatic applyStimulus(input string nm, input logic rst, input logic push,
                               input logic pop, input logic [9:0] pc);
    sb_t e;
    sb_t o;
    RST = rst; PUSH = push; POP = pop; PC_IN = pc;
    @(posedge CLK);
    model_step(rst, push, pop, pc);
    e.nm = nm;
    e.v.sp    = 3'(model_stk.size());
    e.v.empty = (model_stk.size() == 0);
    e.v.full  = (model_stk.size() == DEPTH);
    e.v.err   = model_err;
    e.v.ret   = (model_stk.size() == 0) ? 10'h000 : model_stk[model_stk.size()-1];
    exp_q.push_back(e);
    @(negedge CLK);
    o.nm = nm;
    o.v  = {SP, EMPTY, FULL, ERR, RET_ADDR};
    obs_q.push_back(o);
    RST = 1'b0; PUSH = 1'b0; POP = 1'b0; PC_IN = '0;
  endtask

  task automatic test_reset();
    sb_t e, o;
    applyStimulus("reset", 1, 0, 0, 10'h000);
    applyStimulus("idle_after_reset", 0, 0, 0, 10'h000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_push_pop();
    sb_t e, o;
    applyStimulus("push_055", 0, 1, 0, 10'h055);
    applyStimulus("push_1a3", 0, 1, 0, 10'h1A3);
    applyStimulus("push_3ff", 0, 1, 0, 10'h3FF);
    applyStimulus("pop_1", 0, 0, 1, 10'h000);
    applyStimulus("pop_2", 0, 0, 1, 10'h000);
    applyStimulus("pop_3", 0, 0, 1, 10'h000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_overflow();
    sb_t e, o;
    applyStimulus("ovf_reset", 1, 0, 0, 10'h000);
    for (int i = 1; i <= DEPTH + 1; i++)
      applyStimulus($sformatf("ovf_push_%0d", i), 0, 1, 0, 10'(i));
    for (int i = 1; i <= DEPTH; i++)
      applyStimulus($sformatf("ovf_pop_%0d", i), 0, 0, 1, 10'h000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_underflow();
    sb_t e, o;
    applyStimulus("udf_reset", 1, 0, 0, 10'h000);
    applyStimulus("udf_pop_empty", 0, 0, 1, 10'h000);
    applyStimulus("udf_push_010", 0, 1, 0, 10'h010);
    applyStimulus("udf_push_pop_empty", 1, 0, 0, 10'h000);
    applyStimulus("push_pop_on_empty", 0, 1, 1, 10'h2B7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_replace();
    sb_t e, o;
    applyStimulus("rep_reset", 1, 0, 0, 10'h000);
    applyStimulus("rep_push_020", 0, 1, 0, 10'h020);
    applyStimulus("rep_push_030", 0, 1, 0, 10'h030);
    PUSH = 1'b1; POP = 1'b1; PC_IN = 10'h0AA;
    #1;
    total++;
    if (RET_ADDR !== 10'h030) begin
      bad++;
      $display("[TB] FAIL rep_old_top_during_cycle: got ret=%03h, want ret=030", RET_ADDR);
    end
    applyStimulus("rep_replace_0aa", 0, 1, 1, 10'h0AA);
    applyStimulus("rep_pop", 0, 0, 1, 10'h000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_reset_priority();
    sb_t e, o;
    applyStimulus("rp_pop_empty", 0, 0, 1, 10'h000);
    applyStimulus("rp_push_a", 0, 1, 0, 10'h111);
    applyStimulus("rp_push_b", 0, 1, 0, 10'h222);
    applyStimulus("rp_push_c", 0, 1, 0, 10'h333);
    applyStimulus("rp_reset_with_push", 1, 1, 0, 10'h3C3);
    applyStimulus("rp_idle", 0, 0, 0, 10'h000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e, o;
    applyStimulus("b2b_reset", 1, 0, 0, 10'h000);
    for (int i = 0; i < 24; i++)
      applyStimulus($sformatf("b2b_%0d", i), 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 10'($urandom));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got sp=%0d e=%0b f=%0b err=%0b ret=%03h, want sp=%0d e=%0b f=%0b err=%0b ret=%03h",
                 e.nm, o.v.sp, o.v.empty, o.v.full, o.v.err, o.v.ret,
                 e.v.sp, e.v.empty, e.v.full, e.v.err, e.v.ret);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_reset_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
